// File: rtl/sigma_bus_pkg.sv
// Shared types and helpers for the sigma data-bus arbiter.
// rr_pick scans a request vector starting at a pointer, with wrap-around.
package sigma_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_M      = 8;
  localparam int PICK_W     = 3;

  typedef struct packed {
    logic                    we;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF/8-1:0] be;
    logic [DATA_W_DEF-1:0]   wdata;
  } bus_req_t;

  // Returns the first set index at or after ptr, considering only the low n bits.
  function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_M-1:0]  req_vec,
                                                input logic [PICK_W-1:0] ptr,
                                                input int                n);
    logic [PICK_W-1:0] sel;
    logic              found;
    int                idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_M; i++) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && !found && req_vec[idx[PICK_W-1:0]]) begin
        sel   = idx[PICK_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/sigma_id_fifo.sv
// Synchronous FIFO holding the master IDs of outstanding reads.
// Push while full and pop while empty are ignored.
module sigma_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             srst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sigma_bus_arb.sv
// Round-robin arbiter sharing one sigma bus slave port among NUM_M masters,
// with a grant lock until slave ack and in-order read response routing.
module sigma_bus_arb
  import sigma_bus_pkg::*;
#(
  parameter int NUM_M    = 2,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        srst_n_i,
  input  logic [NUM_M-1:0]            m_req_i,
  input  logic [NUM_M-1:0]            m_we_i,
  input  logic [NUM_M*ADDR_W-1:0]     m_addr_i,
  input  logic [NUM_M*DATA_W/8-1:0]   m_be_i,
  input  logic [NUM_M*DATA_W-1:0]     m_wdata_i,
  output logic [NUM_M-1:0]            m_ack_o,
  output logic [NUM_M-1:0]            m_resp_o,
  output logic [DATA_W-1:0]           m_rdata_o,
  output logic                        s_req_o,
  output logic                        s_we_o,
  output logic [ADDR_W-1:0]           s_addr_o,
  output logic [DATA_W/8-1:0]         s_be_o,
  output logic [DATA_W-1:0]           s_wdata_o,
  input  logic                        s_ack_i,
  input  logic                        s_resp_i,
  input  logic [DATA_W-1:0]           s_rdata_i,
  output logic                        err_o
);

  localparam int IDW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int BEW = DATA_W / 8;

  logic [NUM_M-1:0]  elig;
  logic [PICK_W-1:0] pick;
  logic [IDW-1:0]    grant;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    lock_id;
  logic              lock_vld;
  logic              err_q;
  logic              req_act;
  logic              accept;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [IDW-1:0]    head_id;

  // Reads are masked on a full FIFO even when a response pops it this cycle.
  assign elig    = m_req_i & (m_we_i | {NUM_M{~fifo_full}});
  assign pick    = rr_pick(MAX_M'(elig), PICK_W'(rr_ptr), NUM_M);
  assign grant   = lock_vld ? lock_id : IDW'(pick);
  assign req_act = srst_n_i && (lock_vld || (|elig));
  assign accept  = req_act && s_ack_i;
  assign push    = accept && !m_we_i[grant];
  assign pop     = srst_n_i && s_resp_i && !fifo_empty;

  assign s_req_o   = req_act;
  assign m_rdata_o = pop ? s_rdata_i : '0;
  assign err_o     = err_q && srst_n_i;

  always_comb begin
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    m_ack_o   = '0;
    m_resp_o  = '0;
    if (srst_n_i) begin
      s_we_o    = m_we_i[grant];
      s_addr_o  = m_addr_i[grant*ADDR_W +: ADDR_W];
      s_be_o    = m_be_i[grant*BEW +: BEW];
      s_wdata_o = m_wdata_i[grant*DATA_W +: DATA_W];
    end
    for (int k = 0; k < NUM_M; k++) begin
      m_ack_o[k]  = accept && (grant == IDW'(k));
      m_resp_o[k] = pop && (head_id == IDW'(k));
    end
  end

  // A request left waiting for ack pins the grant until the slave takes it.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr   <= (grant == IDW'(NUM_M - 1)) ? '0 : grant + 1'b1;
        lock_vld <= 1'b0;
      end else if (req_act) begin
        lock_vld <= 1'b1;
        lock_id  <= grant;
      end
      if (s_resp_i && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  sigma_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (RD_DEPTH)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .srst_n_i (srst_n_i),
    .push     (push),
    .wdata    (grant),
    .pop      (pop),
    .rdata    (head_id),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_sigma_bus_arb.sv
// Self-checking bench for sigma_bus_arb: directed scenarios plus random traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_sigma_bus_arb;

  localparam int NUM_M    = 2;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BEW      = DATA_W / 8;
  localparam int RD_DEPTH = 4;

  logic                      clock = 1'b0;
  logic                      srst_n;
  logic [NUM_M-1:0]          mreq;
  logic [NUM_M-1:0]          mwe;
  logic [NUM_M*ADDR_W-1:0]   m_addr;
  logic [NUM_M*BEW-1:0]      m_be;
  logic [NUM_M*DATA_W-1:0]   m_wdata;
  logic [NUM_M-1:0]          m_ack_o;
  logic [NUM_M-1:0]          m_resp_o;
  logic [DATA_W-1:0]         m_rdata_o;
  logic                      s_req_o;
  logic                      s_we_o;
  logic [ADDR_W-1:0]         s_addr_o;
  logic [BEW-1:0]            s_be_o;
  logic [DATA_W-1:0]         s_wdata_o;
  logic                      s_ack;
  logic                      s_resp;
  logic [DATA_W-1:0]         s_rdata;
  logic                      err_o;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int               rr;
  bit               lock_v;
  int               lock_id;
  int               idq[$];
  bit               m_err;
  logic [NUM_M-1:0] exp_ack;

  // Values sampled in the last cycle, for directed scenario checks
  logic             obs_sreq;
  logic [NUM_M-1:0] obs_ack;
  logic [NUM_M-1:0] obs_resp;
  logic [DATA_W-1:0] obs_rdata;
  logic [ADDR_W-1:0] obs_addr;
  logic             obs_err;

  sigma_bus_arb #(
    .NUM_M    (NUM_M),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RD_DEPTH (RD_DEPTH)
  ) dut (
    .clk_i     (clock),
    .srst_n_i  (srst_n),
    .m_req_i   (mreq),
    .m_we_i    (mwe),
    .m_addr_i  (m_addr),
    .m_be_i    (m_be),
    .m_wdata_i (m_wdata),
    .m_ack_o   (m_ack_o),
    .m_resp_o  (m_resp_o),
    .m_rdata_o (m_rdata_o),
    .s_req_o   (s_req_o),
    .s_we_o    (s_we_o),
    .s_addr_o  (s_addr_o),
    .s_be_o    (s_be_o),
    .s_wdata_o (s_wdata_o),
    .s_ack_i   (s_ack),
    .s_resp_i  (s_resp),
    .s_rdata_i (s_rdata),
    .err_o     (err_o)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setMaster(input int k, input bit req, input bit we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    mreq[k]                  = req;
    mwe[k]                   = we;
    m_addr[k*ADDR_W +: ADDR_W] = addr;
    m_be[k*BEW +: BEW]       = '1;
    m_wdata[k*DATA_W +: DATA_W] = wdata;
  endtask

  // One clock cycle: settle, compare DUT against the model, then advance the model.
  task automatic stepCycle();
    int               grant;
    bit               full;
    bit               sreq;
    logic [NUM_M-1:0] elig;
    logic [NUM_M-1:0] eresp;
    #1;
    obs_sreq  = s_req_o;
    obs_ack   = m_ack_o;
    obs_resp  = m_resp_o;
    obs_rdata = m_rdata_o;
    obs_addr  = s_addr_o;
    obs_err   = err_o;
    if (!srst_n) begin
      checkOutput("rst_sreq", 64'(s_req_o), 64'd0);
      checkOutput("rst_ack", 64'(m_ack_o), 64'd0);
      checkOutput("rst_resp", 64'(m_resp_o), 64'd0);
      checkOutput("rst_err", 64'(err_o), 64'd0);
      exp_ack = '0;
      @(posedge clock);
      rr = 0; lock_v = 0; lock_id = 0; m_err = 0;
      idq.delete();
    end else begin
      full  = (idq.size() >= RD_DEPTH);
      grant = -1;
      for (int k = 0; k < NUM_M; k++) elig[k] = mreq[k] && (mwe[k] || !full);
      if (lock_v) grant = lock_id;
      else begin
        for (int i = 0; i < NUM_M; i++)
          if (grant < 0 && elig[(rr + i) % NUM_M]) grant = (rr + i) % NUM_M;
      end
      sreq = (grant >= 0);
      checkOutput("s_req", 64'(s_req_o), 64'(sreq));
      if (sreq) begin
        checkOutput("s_we", 64'(s_we_o), 64'(mwe[grant]));
        checkOutput("s_addr", 64'(s_addr_o), 64'(m_addr[grant*ADDR_W +: ADDR_W]));
        checkOutput("s_be", 64'(s_be_o), 64'(m_be[grant*BEW +: BEW]));
        checkOutput("s_wdata", 64'(s_wdata_o), 64'(m_wdata[grant*DATA_W +: DATA_W]));
      end
      exp_ack = '0;
      if (sreq && s_ack) exp_ack[grant] = 1'b1;
      checkOutput("m_ack", 64'(m_ack_o), 64'(exp_ack));
      eresp = '0;
      if (s_resp && idq.size() > 0) eresp[idq[0]] = 1'b1;
      checkOutput("m_resp", 64'(m_resp_o), 64'(eresp));
      if (eresp != '0) checkOutput("m_rdata", 64'(m_rdata_o), 64'(s_rdata));
      checkOutput("err", 64'(err_o), 64'(m_err));
      @(posedge clock);
      if (s_resp) begin
        if (idq.size() > 0) void'(idq.pop_front());
        else m_err = 1;
      end
      if (sreq && s_ack) begin
        rr     = (grant + 1) % NUM_M;
        lock_v = 0;
        if (!mwe[grant]) idq.push_back(grant);
      end else if (sreq) begin
        lock_v  = 1;
        lock_id = grant;
      end
    end
    @(negedge clock);
  endtask

  // Random masters hold a request until acked; the slave answers only outstanding reads.
  task automatic applyStimulus(input bit allow_new);
    for (int k = 0; k < NUM_M; k++) begin
      if (allow_new && !mreq[k] && $urandom_range(0, 2) == 0)
        setMaster(k, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!mreq[k]) m_be[k*BEW +: BEW] = BEW'($urandom_range(0, 15));
    end
    s_ack   = ($urandom_range(0, 3) != 0);
    s_resp  = (idq.size() > 0) && ($urandom_range(0, 2) == 0);
    s_rdata = $urandom;
    stepCycle();
    mreq = mreq & ~exp_ack;
  endtask

  initial begin
    int guard;
    srst_n = 1'b0; mreq = '1; mwe = '0; m_addr = '1; m_be = '1; m_wdata = '1;
    s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    rr = 0; lock_v = 0; lock_id = 0; m_err = 0; exp_ack = '0;
    @(negedge clock);
    repeat (3) stepCycle();
    srst_n = 1'b1;

    // Fairness: continuous writes from both, always acked
    setMaster(0, 1, 1, 32'h0000_0100, 32'hA);
    setMaster(1, 1, 1, 32'h0000_0200, 32'hB);
    s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("fair_ack", 64'(obs_ack), (i % 2 == 0) ? 64'd1 : 64'd2);
    end

    // Lock: m1 waits for ack while m0 arrives
    setMaster(0, 0, 1, 32'h0, 32'h0);
    setMaster(1, 1, 1, 32'h1000_0001, 32'h55);
    s_ack = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) setMaster(0, 1, 1, 32'h0000_00A0, 32'h66);
      stepCycle();
      checkOutput("lock_addr", 64'(obs_addr), 64'h1000_0001);
      checkOutput("lock_noack", 64'(obs_ack), 64'd0);
    end
    s_ack = 1'b1;
    stepCycle();
    checkOutput("lock_ack_m1", 64'(obs_ack), 64'd2);
    setMaster(1, 0, 1, 32'h0, 32'h0);
    stepCycle();
    checkOutput("lock_ack_m0", 64'(obs_ack), 64'd1);
    setMaster(0, 0, 1, 32'h0, 32'h0);

    // Ordering: reads A (m0), B (m1), C (m0)
    setMaster(0, 1, 0, 32'hA, 32'h0);
    stepCycle(); checkOutput("ord_ack_a", 64'(obs_ack), 64'd1);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    setMaster(1, 1, 0, 32'hB, 32'h0);
    stepCycle(); checkOutput("ord_ack_b", 64'(obs_ack), 64'd2);
    setMaster(1, 0, 0, 32'h0, 32'h0);
    setMaster(0, 1, 0, 32'hC, 32'h0);
    stepCycle(); checkOutput("ord_ack_c", 64'(obs_ack), 64'd1);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    s_resp = 1'b1;
    s_rdata = 32'h11; stepCycle();
    checkOutput("ord_resp1", 64'(obs_resp), 64'd1); checkOutput("ord_data1", 64'(obs_rdata), 64'h11);
    s_rdata = 32'h22; stepCycle();
    checkOutput("ord_resp2", 64'(obs_resp), 64'd2); checkOutput("ord_data2", 64'(obs_rdata), 64'h22);
    s_rdata = 32'h33; stepCycle();
    checkOutput("ord_resp3", 64'(obs_resp), 64'd1); checkOutput("ord_data3", 64'(obs_rdata), 64'h33);
    s_resp = 1'b0;

    // Full: four reads fill the ID FIFO
    for (int i = 0; i < RD_DEPTH; i++) begin
      setMaster(0, 1, 0, 32'h300 + 32'(i), 32'h0);
      stepCycle();
      checkOutput("full_fill_ack", 64'(obs_ack), 64'd1);
    end
    setMaster(0, 1, 0, 32'h400, 32'h0);
    stepCycle(); checkOutput("full_no_req", 64'(obs_sreq), 64'd0);
    setMaster(1, 1, 1, 32'h500, 32'h77);
    stepCycle(); checkOutput("full_wr_ack", 64'(obs_ack), 64'd2);
    setMaster(1, 0, 1, 32'h0, 32'h0);
    s_resp = 1'b1; s_rdata = 32'h44;
    stepCycle();
    checkOutput("full_nobypass", 64'(obs_sreq), 64'd0);
    checkOutput("full_resp", 64'(obs_resp), 64'd1);
    s_resp = 1'b0;
    stepCycle();
    checkOutput("full_rd_req", 64'(obs_sreq), 64'd1);
    checkOutput("full_rd_ack", 64'(obs_ack), 64'd1);
    setMaster(0, 0, 0, 32'h0, 32'h0);
    s_resp = 1'b1;
    for (int i = 0; i < RD_DEPTH; i++) begin
      s_rdata = 32'h50 + 32'(i);
      stepCycle();
      checkOutput("full_drain", 64'(obs_resp), 64'd1);
    end
    s_resp = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) applyStimulus(1'b1);
    guard = 0;
    while ((mreq != '0 || idq.size() > 0) && guard < 300) begin
      applyStimulus(1'b0);
      guard++;
    end
    checkOutput("drain_done", 64'(guard < 300), 64'd1);
    s_ack = 1'b0; s_resp = 1'b0;

    // Error: response with nothing outstanding
    s_resp = 1'b1; s_rdata = 32'hDEAD;
    stepCycle();
    checkOutput("err_noresp", 64'(obs_resp), 64'd0);
    s_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("err_sticky", 64'(obs_err), 64'd1);
    end
    srst_n = 1'b0;
    stepCycle();
    srst_n = 1'b1;
    stepCycle();
    checkOutput("err_cleared", 64'(obs_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
